// File: rtl/kanagawa_fifo_rr_arbiter_if.sv
// Handshake bundle between N upstream FIFO read ports and one downstream FIFO write port.
// The master modport is the arbiter side; the slave modport is the FIFO/environment side.
interface kanagawa_fifo_rr_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]       in_empty;
    logic [NUM_REQ*WIDTH-1:0] in_q;
    logic [NUM_REQ-1:0]       in_rdreq;
    logic                     out_full;
    logic                     out_wrreq;
    logic [WIDTH-1:0]         out_data;
    logic [SRC_W-1:0]         out_src;
    logic [31:0]              grant_count;

    modport master (
        input  in_empty, in_q, out_full,
        output in_rdreq, out_wrreq, out_data, out_src, grant_count
    );

    modport slave (
        output in_empty, in_q, out_full,
        input  in_rdreq, out_wrreq, out_data, out_src, grant_count
    );
endinterface

// File: rtl/kanagawa_fifo_rr_arbiter.sv
// Round-robin N:1 arbiter draining upstream FIFOs into one downstream FIFO, zero latency.
// Optional burst lock (consecutive grants to one requester) enabled by KANAGAWA_ARB_BURST_LOCK_EN.
module kanagawa_fifo_rr_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                        clock,
    input  logic                        rst,
    kanagawa_fifo_rr_arbiter_if.master  bus
);
    localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [SRC_W-1:0] LAST_RST = SRC_W'(NUM_REQ - 1);

    if (NUM_REQ < 1 || MAX_BURST < 1) begin : g_bad_param
        $error("kanagawa_fifo_rr_arbiter: NUM_REQ and MAX_BURST must be >= 1");
    end

    logic [SRC_W-1:0] r_last_ptr;
    logic [31:0]      r_grant_count;

    logic             w_any_elig;
    logic             w_xfer;
    logic             w_rr_found;
    logic [SRC_W-1:0] w_idx;
    logic [SRC_W-1:0] w_rr_win;
    logic [SRC_W-1:0] w_win;

    assign w_any_elig = |(~bus.in_empty);
    assign w_xfer     = !rst && !bus.out_full && w_any_elig;

    // First eligible requester scanning upward from the one after the last winner.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_win   = '0;
        w_idx      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_idx = SRC_W'((32'(r_last_ptr) + k) % NUM_REQ);
            if (!w_rr_found && !bus.in_empty[w_idx]) begin
                w_rr_found = 1'b1;
                w_rr_win   = w_idx;
            end
        end
    end

`ifdef KANAGAWA_ARB_BURST_LOCK_EN
    localparam int unsigned BCNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    logic [BCNT_W-1:0] r_burst_cnt;
    logic              r_burst_act;
    logic              w_lock;

    // Stay on the previous winner while it still has data and the burst budget remains.
    assign w_lock = r_burst_act && (32'(r_burst_cnt) < (MAX_BURST - 1))
                    && !bus.in_empty[r_last_ptr];
    assign w_win  = w_lock ? r_last_ptr : w_rr_win;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_burst_cnt <= '0;
            r_burst_act <= 1'b0;
        end else if (w_xfer) begin
            r_burst_act <= 1'b1;
            r_burst_cnt <= w_lock ? (r_burst_cnt + BCNT_W'(1)) : '0;
        end else if (!bus.out_full && bus.in_empty[r_last_ptr]) begin
            r_burst_act <= 1'b0;
        end
    end
`else
    assign w_win = w_rr_win;
`endif

    // Same-cycle pop/push; everything is forced to zero when no transfer happens.
    always_comb begin
        bus.in_rdreq  = '0;
        bus.out_wrreq = 1'b0;
        bus.out_data  = '0;
        bus.out_src   = '0;
        if (w_xfer) begin
            bus.in_rdreq[w_win] = 1'b1;
            bus.out_wrreq       = 1'b1;
            bus.out_data        = bus.in_q[32'(w_win) * WIDTH +: WIDTH];
            bus.out_src         = w_win;
        end
    end

    assign bus.grant_count = r_grant_count;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_last_ptr    <= LAST_RST;
            r_grant_count <= '0;
        end else if (w_xfer) begin
            r_last_ptr    <= w_win;
            r_grant_count <= r_grant_count + 32'd1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!rst) begin
            assert ($onehot0(bus.in_rdreq))
                else $error("arbiter: in_rdreq has more than one bit set");
            assert ((bus.in_rdreq & bus.in_empty) == '0)
                else $error("arbiter: pop issued to an empty requester");
            assert (!(bus.out_wrreq && bus.out_full))
                else $error("arbiter: push issued while downstream full");
        end
    end
`endif

endmodule

// File: tb/tb_kanagawa_fifo_rr_arbiter.sv
// Bench for kanagawa_fifo_rr_arbiter: per-cycle comparison against a queue/arithmetic model
// plus directed grant sequences with literal expectations and a random empty/full soak.
module tb_kanagawa_fifo_rr_arbiter;
    localparam int N   = 4;
    localparam int W   = 32;
    localparam int MB  = 3;

    logic clock = 1'b0;
    logic rst   = 1'b1;

    kanagawa_fifo_rr_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    kanagawa_fifo_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Model state: last winner, transfer count, length of the current run of grants.
    int          m_last  = N - 1;
    logic [31:0] m_count = '0;
    int          m_run   = 0;
    bit          p_xfer, p_lock, p_clear;
    int          p_win;

    bit          e_xfer, e_lock;
    int          e_win, idx;
    logic [31:0] e_rdreq, e_data;

    int log_src[$];
    int hist[N];
    int pops[N];

    always @(negedge clock) begin
        e_xfer = 1'b0;
        e_lock = 1'b0;
        e_win  = 0;
        if (!rst && !bus.out_full && (bus.in_empty != 4'hF)) begin
            e_xfer = 1'b1;
`ifdef KANAGAWA_ARB_BURST_LOCK_EN
            if (m_run > 0 && m_run < MB && !bus.in_empty[m_last]) begin
                e_lock = 1'b1;
                e_win  = m_last;
            end
`endif
            if (!e_lock) begin
                for (int k = N; k >= 1; k--) begin
                    idx = (m_last + k) % N;
                    if (!bus.in_empty[idx]) e_win = idx;
                end
            end
        end
        e_rdreq = e_xfer ? (32'd1 << e_win) : 32'd0;
        e_data  = e_xfer ? bus.in_q[e_win*W +: W] : 32'd0;

        check("in_rdreq",    32'(bus.in_rdreq), e_rdreq);
        check("out_wrreq",   32'(bus.out_wrreq), 32'(e_xfer));
        check("out_data",    bus.out_data, e_data);
        check("out_src",     32'(bus.out_src), 32'(e_win));
        check("grant_count", bus.grant_count, m_count);

        if (bus.out_wrreq) begin
            log_src.push_back(int'(bus.out_src));
            hist[bus.out_src] = hist[bus.out_src] + 1;
        end
        for (int i = 0; i < N; i++) pops[i] = pops[i] + int'(bus.in_rdreq[i]);

        p_xfer  = e_xfer;
        p_win   = e_win;
        p_lock  = e_lock;
        p_clear = !e_xfer && !rst && !bus.out_full && bus.in_empty[m_last];
    end

    always @(posedge clock) begin
        if (rst) begin
            m_last  <= N - 1;
            m_count <= '0;
            m_run   <= 0;
        end else if (p_xfer) begin
            m_last  <= p_win;
            m_count <= m_count + 32'd1;
            m_run   <= p_lock ? m_run + 1 : 1;
        end else if (p_clear) begin
            m_run   <= 0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_log_at(input string nm, input int i, input int exp);
        check($sformatf("%s[%0d]", nm, i), (i < log_src.size()) ? 32'(log_src[i]) : 32'hFFFF_FFFF,
              32'(exp));
    endtask

`ifdef KANAGAWA_ARB_BURST_LOCK_EN
    int seq_b1[12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
    int seq_b2[6]  = '{0, 0, 0, 1, 2, 2};
`else
    int seq_1[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int seq_2[4] = '{2, 0, 2, 0};
    int seq_3[3] = '{1, 2, 0};
`endif

    initial begin
        bus.in_empty = 4'hF;
        bus.out_full = 1'b0;
        bus.in_q     = {32'hD3D3_0003, 32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};
        for (int i = 0; i < N; i++) begin
            hist[i] = 0;
            pops[i] = 0;
        end

        // Reset held with requesters non-empty: no pops or pushes allowed.
        bus.in_empty = 4'h0;
        cyc(2);
        bus.in_empty = 4'hF;
        rst = 1'b0;
        check("reset_grant_count", bus.grant_count, 32'd0);
        log_src.delete();

`ifdef KANAGAWA_ARB_BURST_LOCK_EN
        bus.in_empty = 4'h0;
        cyc(12);
        bus.in_empty = 4'hF;
        check("b1_len", 32'(log_src.size()), 32'd12);
        foreach (seq_b1[i]) check_log_at("b1_src", i, seq_b1[i]);
        log_src.delete();

        // Requester 1 drains after its first grant: lock drops, round-robin moves on to 2.
        bus.in_empty = 4'h0;
        cyc(4);
        bus.in_empty = 4'b0010;
        cyc(2);
        bus.in_empty = 4'hF;
        check("b2_len", 32'(log_src.size()), 32'd6);
        foreach (seq_b2[i]) check_log_at("b2_src", i, seq_b2[i]);
        check("b2_grant_count", bus.grant_count, 32'd18);
        log_src.delete();
`else
        bus.in_empty = 4'h0;
        cyc(8);
        bus.in_empty = 4'hF;
        check("t1_len", 32'(log_src.size()), 32'd8);
        foreach (seq_1[i]) check_log_at("t1_src", i, seq_1[i]);
        check("t1_grant_count", bus.grant_count, 32'd8);
        log_src.delete();

        // Requester 2 alone, then 0 joins: grants alternate.
        bus.in_empty = 4'b1011;
        cyc(1);
        bus.in_empty = 4'b1010;
        cyc(3);
        bus.in_empty = 4'hF;
        check("t2_len", 32'(log_src.size()), 32'd4);
        foreach (seq_2[i]) check_log_at("t2_src", i, seq_2[i]);
        check("t2_grant_count", bus.grant_count, 32'd12);
        log_src.delete();

        // Downstream full stalls everything, then resume after last winner (0), then reset.
        bus.in_empty = 4'h0;
        bus.out_full = 1'b1;
        cyc(5);
        check("t3_stall_len", 32'(log_src.size()), 32'd0);
        check("t3_stall_count", bus.grant_count, 32'd12);
        bus.out_full = 1'b0;
        cyc(2);
        check("t3_pre_rst_count", bus.grant_count, 32'd14);
        rst = 1'b1;
        cyc(1);
        check("t3_rst_count", bus.grant_count, 32'd0);
        rst = 1'b0;
        cyc(1);
        bus.in_empty = 4'hF;
        check("t3_len", 32'(log_src.size()), 32'd3);
        foreach (seq_3[i]) check_log_at("t3_src", i, seq_3[i]);
        check("t3_grant_count", bus.grant_count, 32'd1);
        log_src.delete();
`endif

        // Random empty/full soak with fresh head data every cycle.
        for (int c = 0; c < 10000; c++) begin
            bus.in_empty = 4'($urandom);
            bus.out_full = ($urandom_range(0, 4) == 0);
            bus.in_q     = {$urandom, $urandom, $urandom, $urandom};
            cyc(1);
        end
        bus.in_empty = 4'hF;
        cyc(1);
        for (int i = 0; i < N; i++)
            check($sformatf("pops_vs_hist[%0d]", i), 32'(pops[i]), 32'(hist[i]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/kanagawa_fifo_rr_arbiter.md
Name: kanagawa_fifo_rr_arbiter

Overview:
- Round-robin N:1 arbiter that drains several upstream register/skid FIFOs (FIFO read side: empty/rdreq/q) into one downstream FIFO (write side: full/wrreq/data).
- Used where multiple call sites share one function-call or memory-request FIFO.
- Issues at most one transfer per cycle, combinationally: upstream pop and downstream push happen in the same cycle.
- Sequential state: round-robin pointer and optional burst counter.

Parameters:
- NUM_REQ, 2, number of requesters (>=1).
- WIDTH, 32, payload width per requester.
- MAX_BURST, 4, maximum consecutive grants to one requester; used only with KANAGAWA_ARB_BURST_LOCK_EN; >=1.
- SRC_W, derived = max(1, clog2(NUM_REQ)), width of source index (localparam).

Ports:
- clock  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_empty  in  NUM_REQ  per-requester upstream FIFO empty
- in_q  in  NUM_REQ*WIDTH  upstream FIFO head data; requester i occupies bits [i*WIDTH +: WIDTH]
- in_rdreq  out  NUM_REQ  pop to upstream FIFO i; one-hot or zero
- out_full  in  1  downstream FIFO full
- out_wrreq  out  1  push to downstream FIFO
- out_data  out  WIDTH  payload of granted requester
- out_src  out  SRC_W  index of granted requester, valid when out_wrreq=1
- grant_count  out  32  total transfers since reset, wraps at 2^32

Behaviour:
- Reset is clock/rst: synchronous, active-high.
- Reset values:
  - last_ptr = NUM_REQ-1, so requester 0 wins first.
  - burst_cnt = 0, grant_count = 0.
  - While rst=1: in_rdreq=0 and out_wrreq=0, regardless of other inputs.
- Eligibility: requester i is eligible when in_empty[i]=0.
- Transfer condition: rst=0, out_full=0, and at least one requester eligible.
- On a transfer:
  - winner = first eligible index scanning last_ptr+1, last_ptr+2, ... modulo NUM_REQ.
  - in_rdreq[winner]=1, out_wrreq=1, out_data = in_q slice of winner, out_src = winner.
  - All of this is combinational, same cycle, 0 latency.
- When there is no transfer: in_rdreq=0, out_wrreq=0, out_src=0, out_data=0. Outputs are zeroed rather than left as don't-care so the bench can check exact values.
- Next-state on a transfer:
  - last_ptr <= winner.
  - grant_count <= grant_count + 1, modulo 2^32.
- With no transfer: last_ptr and grant_count hold.
- out_full=1 blocks everything: no pop, no push, pointer holds. No combinational path from out_full to last_ptr other than via the transfer condition.
- in_q of non-winners is ignored. in_q and out_data are never registered.
- Boundary cases:
  - NUM_REQ=1: always selects 0; out_src constant 0.
  - Pointer wraps from NUM_REQ-1 to 0.
  - An eligible requester is granted at most NUM_REQ-1 grants after becoming eligible, given out_full=0 (burst lock off).
- Reset mid-stream: pointer and count return to reset values on the next edge; no pop/push in the reset cycle.
- Assertions (sim only, guarded like the rest of the runtime):
  - in_rdreq is one-hot0.
  - No in_rdreq[i] while in_empty[i]=1.
  - No out_wrreq while out_full=1.

Optional Feature:
- Macro: KANAGAWA_ARB_BURST_LOCK_EN.
- With the macro defined:
  - After a transfer from requester w with burst_cnt < MAX_BURST-1: if w is still eligible and out_full=0 next cycle, w wins again regardless of the round-robin scan, and burst_cnt increments.
  - Lock is released when w is empty, or when burst_cnt reaches MAX_BURST-1. The next winner is then chosen by normal round-robin from w.
  - Switching to a different requester sets burst_cnt <= 0.
  - out_full=1 holds both burst_cnt and the lock.
  - MAX_BURST=1 is identical to no lock.
- Without the macro: no burst_cnt register; pure round-robin every cycle; MAX_BURST is ignored.

Test Plan:
- Reset, then NUM_REQ=4 with all inputs non-empty and out_full=0 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3; grant_count=8; exactly one in_rdreq bit per cycle.
- Only requester 2 non-empty, then requester 0 also becomes non-empty -> grants 2,0,2,0 alternating; never two in_rdreq bits at once.
- All non-empty, out_full=1 for 5 cycles -> out_wrreq=0 and in_rdreq=0 throughout. On release, the grant resumes at the next index after the last winner; grant_count unchanged during the stall.
- rst asserted mid-stream after winner 2 -> next transfer after reset goes to requester 0; grant_count=0.
- KANAGAWA_ARB_BURST_LOCK_EN, MAX_BURST=3, all non-empty -> out_src 0,0,0,1,1,1,2,2,2,3,3,3. If requester 1 empties after 1 grant, the next grant goes to 2 and burst_cnt resets.
- Random empty/full stimulus for 10k cycles -> all assertions hold; per-requester pop counts match the out_src histogram; out_data equals the in_q slice of out_src every transfer cycle.
